// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder
//   Stochastic-to-binary decoder. Sums NUM_WORDS consecutive per-word ones
//   counts (each 0..NUM_BITS) into one window result. The output has one
//   result of buffering: out_sum plus a single pending slot. While the
//   pending slot is occupied, the input is back-pressured.
// Ports
//   clk, rst              clock and async active-high reset
//   in_count/in_valid     per-word ones count; in_ready accepts the beat
//   clear                 synchronous discard of the partial window
//   out_sum/out_valid     completed window sum; out_ready consumes it
//   err                   sticky: an accepted count exceeded NUM_BITS
module sc_stream_decoder #(
  parameter int NUM_BITS  = 8,
  parameter int CNT_W     = 4,
  parameter int NUM_WORDS = 32,
  parameter int SUM_W     = $clog2(NUM_BITS*NUM_WORDS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_BITS);
  localparam logic [WC_W-1:0]  LAST_WC = WC_W'(NUM_WORDS-1);

  typedef enum logic {ACCUM, STALL} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc, pending;
  logic [WC_W-1:0]  word_cnt;

  logic             accept, over, last;
  logic [SUM_W-1:0] clamped, sum_next;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign over     = in_count > MAX_CNT;
  assign clamped  = over ? SUM_W'(MAX_CNT) : SUM_W'(in_count);
  assign sum_next = acc + clamped;
  assign last     = (word_cnt == LAST_WC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      word_cnt  <= '0;
      pending   <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      // A beat discarded by clear is still accepted, so it still flags err.
      if (accept && over) err <= 1'b1;

      case (state)
        ACCUM: begin
          // Default: drop out_valid on consumption; a same-cycle load below
          // overrides this and keeps it high.
          if (out_valid && out_ready) out_valid <= 1'b0;

          if (clear) begin
            acc      <= '0;
            word_cnt <= '0;
          end else if (accept) begin
            if (last) begin
              acc      <= '0;
              word_cnt <= '0;
              if (!out_valid || out_ready) begin
                out_sum   <= sum_next;
                out_valid <= 1'b1;
              end else begin
                pending <= sum_next;
                state   <= STALL;
              end
            end else begin
              acc      <= sum_next;
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        STALL: begin
          // out_valid is necessarily 1 here; it stays 1 as pending moves up.
          if (out_ready) begin
            out_sum <= pending;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Testbench for sc_stream_decoder: a table of whole windows, directed
// multi-cycle sequences, then randomized traffic, all against a
// queue-based reference model of outstanding results.
module tb_sc_stream_decoder;

  localparam int NB = 8;
  localparam int NW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_count;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
  logic [8:0] out_sum;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  sc_stream_decoder #(.NUM_BITS(NB), .CNT_W(4), .NUM_WORDS(NW), .SUM_W(9)) dut (
    .clk(clk), .rst(rst), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: results not yet consumed (at most two: the visible one
  // and one held back), plus the partial window as a running sum/beat count.
  int q[$];
  int part_sum, part_n;
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part_sum = 0;
    part_n   = 0;
    m_err    = 0;
  endtask

  // Drive one cycle: compare DUT against model, advance model, clock.
  task automatic step(input int c, input bit v, input bit clr, input bit ordy);
    bit acc_ok, consume, done;
    int res;
    in_count  = 4'(c);
    in_valid  = v;
    clear     = clr;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("out_sum", out_sum, q[0]);
    chk("err", err, m_err);

    acc_ok  = v && (q.size() < 2);
    consume = (q.size() > 0) && ordy;
    done    = 0;
    res     = 0;
    if (acc_ok && c > NB) m_err = 1;
    if (clr && q.size() < 2) begin
      part_sum = 0;
      part_n   = 0;
    end else if (acc_ok) begin
      part_sum += (c > NB) ? NB : c;
      part_n++;
      if (part_n == NW) begin
        done = 1;
        res  = part_sum;
        part_sum = 0;
        part_n   = 0;
      end
    end
    if (consume) void'(q.pop_front());
    if (done) q.push_back(res);
    @(posedge clk);
    #1;
  endtask

  task automatic window(input int a, input int b, input bit ordy);
    for (int i = 0; i < NW; i++) step((i % 2 == 0) ? a : b, 1'b1, 1'b0, ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst out_sum", out_sum, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst err", err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int a;
    int b;
    int exp_sum;
  } win_vec_t;

  win_vec_t vecs[7];

  initial begin
    vecs[0] = '{8, 8, 256};
    vecs[1] = '{3, 5, 128};
    vecs[2] = '{1, 1, 32};
    vecs[3] = '{0, 0, 0};
    vecs[4] = '{4, 4, 128};
    vecs[5] = '{0, 8, 128};
    vecs[6] = '{7, 2, 144};

    rst = 1'b1; in_count = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_sum", out_sum, 0);
    chk("reset err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back windows, consumer always ready: each result appears the
    // cycle after its 32nd beat while the next window streams in.
    for (int k = 0; k < 7; k++) begin
      window(vecs[k].a, vecs[k].b, 1'b1);
      chk("table out_valid", out_valid, 1);
      chk("table out_sum", out_sum, vecs[k].exp_sum);
    end
    step(0, 1'b0, 1'b0, 1'b1);
    chk("single-cycle valid", out_valid, 0);

    // Stall: two windows with no consumer.
    window(1, 1, 1'b0);
    chk("stall first sum", out_sum, 32);
    window(2, 2, 1'b0);
    chk("stall in_ready low", in_ready, 0);
    chk("stall holds sum", out_sum, 32);
    step(0, 1'b0, 1'b0, 1'b1);
    chk("stall release sum", out_sum, 64);
    chk("stall release valid", out_valid, 1);
    chk("stall release ready", in_ready, 1);
    step(0, 1'b0, 1'b0, 1'b1);
    chk("stall drained", out_valid, 0);

    // Clear with a same-cycle beat discards the partial window and the beat.
    for (int i = 0; i < 10; i++) step(8, 1'b1, 1'b0, 1'b1);
    step(8, 1'b1, 1'b1, 1'b1);
    window(1, 1, 1'b1);
    chk("clear out_sum", out_sum, 32);

    // Out-of-range count is clamped and flags err, which stays sticky.
    for (int i = 0; i < NW-1; i++) step(0, 1'b1, 1'b0, 1'b1);
    step(12, 1'b1, 1'b0, 1'b1);
    chk("clamp out_sum", out_sum, 8);
    chk("clamp err", err, 1);
    window(2, 2, 1'b1);
    chk("err sticky", err, 1);

    // Reset mid-window, then while holding a result.
    for (int i = 0; i < 20; i++) step(8, 1'b1, 1'b0, 1'b1);
    do_reset();
    window(3, 3, 1'b0);
    chk("pre-rst valid", out_valid, 1);
    do_reset();
    window(4, 4, 1'b1);
    chk("post-rst out_sum", out_sum, 128);
    step(0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int c;
      c = ($urandom_range(0, 49) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary decoder that sits directly downstream of the parallel bitstream accumulator. Each cycle it takes the accumulator's per-word ones count (0..NUM_BITS). It sums NUM_WORDS consecutive counts into one binary estimate of the stream probability, so the result is the number of ones in NUM_BITS×NUM_WORDS stream bits. It presents each completed window result on a valid/ready output with one result of buffering, and back-pressures the input when that buffering is full.

## Interface
- NUM_BITS, 8: stream bits per input word; maximum legal in_count.
- CNT_W, 4: width of in_count; must hold NUM_BITS.
- NUM_WORDS, 32: words per window, ≥1.
- SUM_W, $clog2(NUM_BITS*NUM_WORDS+1) = 9: width of out_sum.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_count  input  CNT_W  ones count of the current stream word.
- in_valid  input  1  in_count is valid this cycle.
- in_ready  output  1  decoder accepts a beat this cycle.
- clear  input  1  synchronous discard of the partial window.
- out_sum  output  SUM_W  completed window sum.
- out_valid  output  1  out_sum holds an unconsumed result.
- out_ready  input  1  consumer takes out_sum this cycle.
- err  output  1  sticky flag: an accepted in_count exceeded NUM_BITS.

## Operation
- Beat accepted when in_valid && in_ready. in_ready = (state == ACCUM); it depends only on registered state.
- Out-of-range in_count on an accepted beat: the value is clamped to NUM_BITS and err is set. err is cleared only by rst.
- acc (SUM_W bits) holds the partial sum. word_cnt (0..NUM_WORDS-1) counts accepted beats in the window.
- Non-final accepted beat: acc += clamped count; word_cnt++.
- Final beat (word_cnt == NUM_WORDS-1): final = acc + clamped count.
  - If the output slot is free (!out_valid || out_ready): out_sum ← final, out_valid ← 1, acc ← 0, word_cnt ← 0, stay in ACCUM.
  - Otherwise: pending ← final, acc ← 0, word_cnt ← 0, go to STALL.
- STALL (in_ready = 0): out_valid is 1 throughout. When out_ready: out_sum ← pending, out_valid stays 1, go to ACCUM.
- out_valid falls when out_valid && out_ready and no new result loads that cycle.
- clear:
  - In ACCUM: acc ← 0 and word_cnt ← 0. clear wins over a same-cycle accepted beat, which is discarded but still consumed.
  - In STALL: clear is ignored.
  - clear never touches out_sum, out_valid, pending or err.
- Arithmetic never overflows: the maximum sum NUM_BITS×NUM_WORDS fits in SUM_W.

## Timing
- Reset values: state = ACCUM, acc = 0, word_cnt = 0, pending = 0, out_sum = 0, out_valid = 0, err = 0. in_ready = 1 during and after reset.
- Latency: out_valid and out_sum update on the edge that accepts the final beat, so they are visible the next cycle.
- Throughput:
  - With out_ready held high, one beat is accepted every cycle and one result is produced every NUM_WORDS cycles, with no bubbles.
  - Back-to-back windows remain gap-free when the consumer drains the output in the same cycle the next result completes.
- Simultaneous final beat and out_ready with out_valid = 1: the old result is consumed, the new result loads, and out_valid stays 1.
- In STALL, out_ready causes pending to move to out_sum on that edge. in_ready returns the next cycle.
- Reset asserted mid-window or while holding a result: all state returns to reset values immediately. The partial window and pending result are lost.
- NUM_WORDS = 1: every accepted beat is a final beat.

## Test plan
- 32 beats of in_count=8, out_ready=1 → out_sum=256, out_valid high for exactly one cycle, the cycle after the 32nd beat; err=0.
- 32 beats alternating 3,5, out_ready=1 → out_sum=128. A second back-to-back window of 32×1 → out_sum=32 exactly 32 cycles later, with in_ready never low.
- out_ready=0, window of 32×1 followed by a window of 32×2:
  - out_sum holds 32.
  - in_ready drops the cycle after the 64th beat.
  - Raise out_ready for one cycle → out_sum=64, out_valid stays 1, in_ready returns high.
- 10 beats of 8, then clear together with a beat of 8, then 32 beats of 1 → out_sum=32.
- 31 beats of 0 plus one beat of in_count=12 → out_sum=8, err=1. err remains 1 across later windows until rst.
- rst pulse after 20 beats of 8, and again while out_valid=1 → all outputs 0 and in_ready=1. The following window of 32×4 → out_sum=128.
